instr_fetch_unit: RTL and testbench

- Fetch stage of the MIPS32 core. Holds the PC and fetches instructions from instruction memory over a req/ack handshake.
- Presents each instruction on `ir` to the decode/branch-comparator stage.
- Consumes the comparator's registered `branch_yes` one cycle after a branch is issued, and redirects the PC on taken branches and on J.
- Sits directly upstream of the 32-bit branch comparator: feeds its IR input and consumes its branch decision.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/next_pc_calc.sv | 17 +
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 core definitions: opcodes, the fetch FSM state encoding and
// the default reset vector.
package mips_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h08;
  localparam logic [5:0] OP_BNE = 6'h09;
  localparam logic [5:0] OP_BGE = 6'h0A;
  localparam logic [5:0] OP_BGT = 6'h0B;
  localparam logic [5:0] OP_BLE = 6'h0C;
  localparam logic [5:0] OP_BLT = 6'h0D;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_RESOLVE = 2'd3
  } fetch_state_t;

  // Branch opcodes occupy one contiguous block, in comparator order.
  function automatic logic is_branch(input logic [5:0] op);
    return (op >= OP_BEQ) && (op <= OP_BLT);
  endfunction

  function automatic logic is_jump(input logic [5:0] op);
    return op == OP_J;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Candidate next-PC values for the fetch FSM; all arithmetic wraps modulo 2^32.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic        branch_yes,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [31:0] resolve_target
);

  assign pc_plus4       = pc + 32'd4;
  assign branch_target  = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};
  assign jump_target    = {pc_plus4[31:28], ir[25:0], 2'b00};
  assign resolve_target = branch_yes ? branch_target : pc_plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over imem req/ack, presents ir to decode
// with a valid/ready handshake and redirects on J and resolved branches.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  output logic             ir_valid,
  input  logic             ir_ready,
  input  logic             branch_yes,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] fetch_count,
  output fetch_state_t     dbg_state
);

  // Handshakes: imem_req stays high with imem_addr stable until a cycle with
  // imem_ack; ir_valid stays high with ir/pc stable until a cycle with
  // ir_ready, and that rising edge is the single point of transfer.

  fetch_state_t state, state_next;
  logic [31:0]  pc_plus4, branch_target, jump_target, resolve_target;
  logic [5:0]   opcode;

  assign opcode = ir[31:26];

  next_pc_calc u_next_pc (
    .pc            (pc),
    .ir            (ir),
    .branch_yes    (branch_yes),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .resolve_target(resolve_target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    state_next = ST_FETCH;
      ST_FETCH:   if (imem_ack) state_next = ST_ISSUE;
      ST_ISSUE:   if (ir_ready) state_next = is_branch(opcode) ? ST_RESOLVE : ST_FETCH;
      ST_RESOLVE: state_next = ST_FETCH;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_valid = 1'b0;
    case (state)
      ST_FETCH: imem_req = 1'b1;
      ST_ISSUE: ir_valid = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;
  assign dbg_state = state;

  // On a branch accept, pc and ir stay put so the comparator's registered
  // decision lines up with this IR during RESOLVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      ir          <= 32'd0;
      fetch_count <= '0;
    end else begin
      case (state)
        ST_FETCH: if (imem_ack) ir <= imem_rdata;
        ST_ISSUE: if (ir_ready) begin
          fetch_count <= fetch_count + CNT_W'(1);
          if (is_jump(opcode))         pc <= jump_target;
          else if (!is_branch(opcode)) pc <= pc_plus4;
        end
        ST_RESOLVE: pc <= resolve_target;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a next-address
// reference model and an expected fetch-address queue.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack = 1'b0;
  logic [31:0]  imem_rdata = 32'd0;
  logic [31:0]  ir;
  logic         ir_valid;
  logic         ir_ready = 1'b0;
  logic         branch_yes = 1'b0;
  logic [31:0]  pc;
  logic [31:0]  fetch_count;
  fetch_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_req_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_count = 0;

  instr_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .branch_yes (branch_yes),
    .pc         (pc),
    .fetch_count(fetch_count),
    .dbg_state  (dbg_state)
  );

  // Clock / cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: where fetch goes after the instruction w at address a.
  function automatic logic [31:0] ref_next(input logic [31:0] a, input logic [31:0] w,
                                           input logic by);
    logic [31:0] p4;
    int          simm;
    int unsigned op;
    p4   = a + 32'd4;
    op   = w[31:26];
    simm = $signed(w[15:0]);
    if (op == 2) return {p4[31:28], w[25:0], 2'b00};
    if (op >= 8 && op <= 13 && by) return p4 + 32'(simm * 4);
    return p4;
  endfunction

  function automatic logic op_is_branch(input logic [31:0] w);
    return (w[31:26] >= 6'd8) && (w[31:26] <= 6'd13);
  endfunction

  task automatic check_reset_values(input string where);
    check_eq({where, "_imem_req"}, 32'(imem_req), 32'd0);
    check_eq({where, "_ir_valid"}, 32'(ir_valid), 32'd0);
    check_eq({where, "_ir"}, ir, 32'd0);
    check_eq({where, "_pc"}, pc, 32'd0);
    check_eq({where, "_fetch_count"}, fetch_count, 32'd0);
  endtask

  task automatic restart_model();
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_count = 0;
  endtask

  // Release reset at a negedge while a stray ack is offered in IDLE.
  task automatic release_reset();
    @(negedge clk);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    @(negedge clk);
    imem_ack   = 1'b0;
    check_eq("idle_ack_ignored_ir", ir, 32'd0);
    check_eq("first_req_after_reset", 32'(imem_req), 32'd1);
    restart_model();
  endtask

  // Driver: one instruction through fetch, issue and (for branches) resolve.
  task automatic do_instr(input logic [31:0] word, input int delay, input int stall,
                          input logic by, input logic pulse, input logic rst_resolve,
                          input logic chk_gap);
    logic [31:0] a;
    for (int i = 0; i < 50; i++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    if (!imem_req) begin
      check_eq("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'd0, 32'd1);
      return;
    end
    a = exp_q.pop_front();
    check_eq("imem_addr", imem_addr, a);
    if (chk_gap) check_eq("fetch_gap", 32'(cyc - last_req_cyc), 32'd2);
    last_req_cyc = cyc;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check_eq("req_hold", 32'(imem_req), 32'd1);
      check_eq("addr_hold", imem_addr, a);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check_eq("ir_valid_issue", 32'(ir_valid), 32'd1);
    check_eq("ir", ir, word);
    check_eq("pc_issue", pc, a);
    check_eq("req_low_issue", 32'(imem_req), 32'd0);
    for (int s = 0; s < stall; s++) begin
      branch_yes = pulse;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      check_eq("stall_ir", ir, word);
      check_eq("stall_pc", pc, a);
      check_eq("stall_ir_valid", 32'(ir_valid), 32'd1);
      check_eq("stall_count", fetch_count, exp_count);
    end
    imem_ack   = 1'b0;
    branch_yes = pulse;
    ir_ready   = 1'b1;
    @(negedge clk);
    ir_ready   = 1'b0;
    branch_yes = 1'b0;
    exp_count  = exp_count + 1;
    check_eq("fetch_count", fetch_count, exp_count);
    if (op_is_branch(word)) begin
      check_eq("resolve_ir_valid", 32'(ir_valid), 32'd0);
      check_eq("resolve_req", 32'(imem_req), 32'd0);
      check_eq("resolve_ir_held", ir, word);
      check_eq("resolve_pc_held", pc, a);
      if (rst_resolve) begin
        #2 rst = 1'b1;
        #1 check_reset_values("rst_resolve");
        release_reset();
        return;
      end
      branch_yes = by;
      @(negedge clk);
      branch_yes = 1'b0;
    end
    exp_q.push_back(ref_next(a, word, by));
  endtask

  task automatic reset_in_fetch(input int wait_cycles);
    for (int i = 0; i < 50; i++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    check_eq("rst_fetch_req_seen", 32'(imem_req), 32'd1);
    for (int i = 0; i < wait_cycles; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("rst_fetch");
    release_reset();
  endtask

  function automatic logic [31:0] rand_word();
    int unsigned kind;
    logic [5:0]  op;
    logic [31:0] w;
    kind = $urandom_range(0, 3);
    w    = $urandom;
    case (kind)
      0:       op = 6'h00;
      1:       op = 6'($urandom_range(8, 13));
      2:       op = 6'h02;
      default: begin
        op = 6'($urandom_range(0, 63));
        if (op == 6'h02 || (op >= 6'h08 && op <= 6'h0D)) op = 6'h23;
      end
    endcase
    w[31:26] = op;
    return w;
  endfunction

  initial begin
    // Reset state (asynchronous assertion before any clock edge).
    #1 rst = 1'b1;
    #2 check_reset_values("por");
    @(negedge clk);
    release_reset();

    // Sequential run: 0,4,8,C at one instruction every 2 cycles.
    for (int i = 0; i < 4; i++) do_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, i > 0);
    check_eq("count_after_4", fetch_count, 32'd4);

    // Taken branches at 0x10: +3 words then -4 words.
    do_instr({6'h08, 10'h0, 16'h0003}, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr({6'h02, 26'h0000004}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr({6'h08, 10'h0, 16'hFFFC}, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Jump to 0x40, not-taken BNE with branch_yes pulsed during ISSUE.
    do_instr({6'h02, 26'h0000010}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr({6'h09, 10'h0, 16'h0010}, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    // Jump chain 0x44 -> 0x0FFF_FFFC -> 0x1000_0008 -> 0x1000_0400.
    do_instr({6'h02, 26'h3FFFFFF}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr({6'h02, 26'h0000002}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr({6'h02, 26'h0000100}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Slow memory and downstream stall.
    do_instr(32'h2000_1234, 5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("addr_after_jumps", exp_q[0], 32'h1000_0408);

    // Randomized traffic.
    for (int i = 0; i < 60; i++)
      do_instr(rand_word(), $urandom_range(0, 3), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    // Async reset while a fetch waits for its ack.
    reset_in_fetch(2);
    do_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Async reset during RESOLVE.
    do_instr({6'h0B, 10'h0, 16'h0040}, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    // Wrap: branch from 0 to 0xFFFF_FFFC, then sequential wraps to 0.
    do_instr({6'h08, 10'h0, 16'hFFFE}, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("count_final", fetch_count, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
